// File: rtl/dmem_lsu_pkg.sv
// Shared types, constants and request-classification helpers for the load/store unit.
package dmem_lsu_pkg;

  localparam int unsigned WORD_LEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_DATA,
    ST_WR,
    ST_ERR
  } lsu_state_e;

  // Reserved funct3 codes, and stores that ask for an unsigned width.
  function automatic logic f3_illegal(input logic wen, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wen && f3[2]);
  endfunction

  // f3[1:0] = size: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits to the natural alignment of the access size.
  function automatic logic [WORD_LEN-1:0] align_addr(input logic [1:0] size,
                                                     input logic [WORD_LEN-1:0] addr);
    logic [WORD_LEN-1:0] a;
    a = addr;
    if (size == 2'b01) a[0] = 1'b0;
    if (size == 2'b10) a[1:0] = 2'b00;
    return a;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of the load/store unit.
interface dmem_lsu_if;
  import dmem_lsu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [2:0]          req_funct3;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_err;
  logic [WORD_LEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/dmem_lsu_data_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_data_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          lane_i,
  input  logic [WORD_LEN-1:0] rdata_i,
  input  logic [WORD_LEN-1:0] wdata_i,
  output logic [WORD_LEN-1:0] load_data_o,
  output logic [WORD_LEN-1:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half from the read word and extend it per funct3.
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{(WORD_LEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {{(WORD_LEN-8){1'b0}}, byte_sel};
      F3_H:    load_data_o = {{(WORD_LEN-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {{(WORD_LEN-16){1'b0}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Replace the addressed lane of the read word with the low bits of the store data.
  always_comb begin
    store_data_o = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        case (lane_i)
          2'd0:    store_data_o[7:0]   = wdata_i[7:0];
          2'd1:    store_data_o[15:8]  = wdata_i[7:0];
          2'd2:    store_data_o[23:16] = wdata_i[7:0];
          default: store_data_o[31:24] = wdata_i[7:0];
        endcase
      end
      2'b01: begin
        if (lane_i[1]) store_data_o[31:16] = wdata_i[15:0];
        else           store_data_o[15:0]  = wdata_i[15:0];
      end
      default: store_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: RV32I loads/stores onto a word-wide, 1-cycle-read memory port.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_lsu_if.slave           core,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata
);

  lsu_state_e          state_q, state_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                wen_q, wen_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [WORD_LEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORD_LEN-1:0] load_data, store_data;
  logic                req_bad;

  lsu_data_align u_align (
    .funct3_i     (f3_q),
    .lane_i       (addr_q[1:0]),
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  assign req_bad = f3_illegal(core.req_wen, core.req_funct3) ||
                   (MISALIGN_TRAP && misaligned(core.req_funct3[1:0], core.req_addr[1:0]));

  // Next-state, request latching and registered response.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    wen_d        = wen_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          addr_d  = MISALIGN_TRAP ? core.req_addr
                                  : align_addr(core.req_funct3[1:0], core.req_addr);
          wdata_d = core.req_wdata;
          f3_d    = core.req_funct3;
          wen_d   = core.req_wen;
          if (req_bad) begin
            // Error response is registered here so it appears in C1.
            state_d      = ST_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (core.req_wen && core.req_funct3 == F3_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_DATA;
      ST_DATA: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        if (!wen_q) resp_rdata_d = load_data;
      end
      ST_WR: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      wen_q        <= wen_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory port driven from state so mem_wen falls as soon as reset asserts.
  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_RD: mem_addr = addr_q;
      ST_DATA: begin
        mem_addr = addr_q;
        if (wen_q) begin
          mem_wen   = 1'b1;
          mem_wdata = store_data;
        end
      end
      ST_WR: begin
        mem_addr  = addr_q;
        mem_wen   = 1'b1;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 1-cycle-read word memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_wen;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  dmem_lsu_if bus();

  dmem_lsu #(.MISALIGN_TRAP(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (bus),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata)
  );

  always @(posedge clk) begin
    if (preload) mem[10'h040] <= 32'h8765_43F1;
    else if (mem_wen) mem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Issues one request (caller sits just after a negedge) and observes up to 8 cycles.
  task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic err,
                         output logic [31:0] rdata, output int wcnt, output int wcyc,
                         output logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; err = 1'b0; rdata = '0; wcnt = 0; wcyc = 0; wd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wen) begin
        wcnt++;
        wcyc = c;
        wd = mem_wdata;
      end
      if (bus.resp_valid) begin
        lat = c;
        err = bus.resp_err;
        rdata = bus.resp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wcyc;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat, wcnt, wcyc;
    logic        err;
    logic [31:0] rdata, wd;

    vecs[0]  = '{"lb100",   1'b0, F3_B,   32'h100, 32'h0,         1'b0, 32'hFFFF_FFF1, 3, 0, 32'h0};
    vecs[1]  = '{"lbu100",  1'b0, F3_BU,  32'h100, 32'h0,         1'b0, 32'h0000_00F1, 3, 0, 32'h0};
    vecs[2]  = '{"lb101",   1'b0, F3_B,   32'h101, 32'h0,         1'b0, 32'h0000_0043, 3, 0, 32'h0};
    vecs[3]  = '{"lh102",   1'b0, F3_H,   32'h102, 32'h0,         1'b0, 32'hFFFF_8765, 3, 0, 32'h0};
    vecs[4]  = '{"lhu102",  1'b0, F3_HU,  32'h102, 32'h0,         1'b0, 32'h0000_8765, 3, 0, 32'h0};
    vecs[5]  = '{"sb103",   1'b1, F3_B,   32'h103, 32'h1234_56AA, 1'b0, 32'h0,         3, 2, 32'hAA65_43F1};
    vecs[6]  = '{"lw100",   1'b0, F3_W,   32'h100, 32'h0,         1'b0, 32'hAA65_43F1, 3, 0, 32'h0};
    vecs[7]  = '{"lb103",   1'b0, F3_B,   32'h103, 32'h0,         1'b0, 32'hFFFF_FFAA, 3, 0, 32'h0};
    vecs[8]  = '{"lw102e",  1'b0, F3_W,   32'h102, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0};
    vecs[9]  = '{"sh101e",  1'b1, F3_H,   32'h101, 32'hBEEF,      1'b1, 32'h0,         1, 0, 32'h0};
    vecs[10] = '{"f3_011e", 1'b0, 3'b011, 32'h100, 32'h0,         1'b1, 32'h0,         1, 0, 32'h0};
    vecs[11] = '{"sbu_e",   1'b1, F3_BU,  32'h100, 32'hFF,        1'b1, 32'h0,         1, 0, 32'h0};

    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    // Reset values, before any clock edge.
    #2;
    check("rst resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst resp_err",   {31'b0, bus.resp_err},   32'h0);
    check("rst mem_wen",    {31'b0, mem_wen},        32'h0);
    check("rst resp_rdata", bus.resp_rdata,          32'h0);
    check("rst mem_addr",   mem_addr,                32'h0);
    @(posedge clk); @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst req_ready", {31'b0, bus.req_ready}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rdata, wcnt, wcyc, wd);
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
      check({vecs[i].name, " err"}, {31'b0, err}, {31'b0, vecs[i].err});
      check({vecs[i].name, " rdata"}, rdata, vecs[i].rdata);
      check({vecs[i].name, " wen count"}, wcnt, (vecs[i].wcyc != 0) ? 1 : 0);
      check({vecs[i].name, " wen cycle"}, wcyc, vecs[i].wcyc);
      if (vecs[i].wcyc != 0) check({vecs[i].name, " mem_wdata"}, wd, vecs[i].mwdata);
      @(negedge clk);
    end

    // SW then LW issued in the SW's resp_valid cycle.
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h104; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("sw c1 mem_wen",    {31'b0, mem_wen}, 32'h1);
    check("sw c1 mem_wdata",  mem_wdata, 32'hDEAD_BEEF);
    check("sw c1 resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    check("sw c2 resp_valid", {31'b0, bus.resp_valid}, 32'h1);
    check("sw c2 req_ready",  {31'b0, bus.req_ready}, 32'h1);
    check("sw c2 mem_wen",    {31'b0, mem_wen}, 32'h0);
    run_req(1'b0, F3_W, 32'h104, 32'h0, lat, err, rdata, wcnt, wcyc, wd);
    check("b2b lw latency", lat, 3);
    check("b2b lw rdata", rdata, 32'hDEAD_BEEF);
    check("b2b lw err", {31'b0, err}, 32'h0);
    @(negedge clk);

    // Reset in the write cycle of an SH read-modify-write.
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("sh c2 mem_wen",   {31'b0, mem_wen}, 32'h1);
    check("sh c2 mem_wdata", mem_wdata, 32'hAA65_BEEF);
    rst_n = 1'b0;
    #1;
    check("abort mem_wen", {31'b0, mem_wen}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst req_ready", {31'b0, bus.req_ready}, 32'h1);
    wcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid) wcnt++;
    end
    check("abort no resp", wcnt, 0);
    check("abort mem kept", mem[10'h040], 32'hAA65_43F1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
